// File: rtl/buffer_mux_pkg.sv
// Shared defaults and the round-robin grant search for buffer_arb_mux.
package buffer_mux_pkg;

  localparam int DEF_DATA_WIDTH = 40;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int MAX_CH         = 16;

  // First requesting channel searching upward from last+1 (wrapping); -1 if none.
  function automatic int rr_next_grant(input logic [MAX_CH-1:0] nonempty,
                                       input int last,
                                       input int num_ch);
    int idx;
    int grant;
    grant = -1;
    for (int off = 1; off <= MAX_CH; off++) begin
      idx = last + off;
      if (idx >= num_ch) begin
        idx = idx - num_ch;
      end else begin
        idx = idx;
      end
      if ((off <= num_ch) && (grant < 0) && nonempty[idx[3:0]]) begin
        grant = idx;
      end else begin
        grant = grant;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/buffer_fifo.sv
// Per-channel FIFO: wrap-around pointers plus a separate occupancy count.
module buffer_fifo #(
  parameter int DATA_WIDTH = 40,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  push_ok_s, pop_ok_s;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == {CNT_W{1'b0}});
  assign rdata = mem_q[rd_ptr_q];

  // Requests are gated by full/empty so the FIFO can never over- or underflow.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    wr_ptr_d  = push_ok_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
    end else begin
      mem_d = mem_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/buffer_arb_mux.sv
// Buffered N:1 mux with fixed-select or round-robin arbitration and a registered output.
// Round-robin support is compiled in only when BUFFER_ARB_MUX_RR_EN is defined.
module buffer_arb_mux
  import buffer_mux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]             selector,
  input  logic                         rr_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_ch
);

  logic [NUM_CH-1:0]     full_s, empty_s, pop_s;
  logic [DATA_WIDTH-1:0] rdata_s [NUM_CH];
  logic [SEL_W-1:0]      grant_s;
  logic                  grant_ok_s, fix_ok_s, load_s;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_ch_q, out_ch_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    buffer_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid[c]),
      .pop   (pop_s[c]),
      .wdata (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .rdata (rdata_s[c]),
      .full  (full_s[c]),
      .empty (empty_s[c])
    );
  end

  assign in_ready  = ~full_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

  // Out-of-range selectors never grant.
  always_comb begin
    fix_ok_s = 1'b0;
    if (int'(selector) < NUM_CH) begin
      fix_ok_s = !empty_s[selector];
    end else begin
      fix_ok_s = 1'b0;
    end
  end

`ifdef BUFFER_ARB_MUX_RR_EN
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;
  logic [MAX_CH-1:0] nonempty_s;
  int                rr_pick_s;

  always_comb begin
    grant_s    = selector;
    grant_ok_s = fix_ok_s;
    nonempty_s = '0;
    nonempty_s[NUM_CH-1:0] = ~empty_s;
    rr_pick_s  = rr_next_grant(nonempty_s, int'(last_grant_q), NUM_CH);
    if (rr_mode) begin
      if (rr_pick_s >= 0) begin
        grant_s    = SEL_W'(rr_pick_s);
        grant_ok_s = 1'b1;
      end else begin
        grant_s    = '0;
        grant_ok_s = 1'b0;
      end
    end else begin
      grant_s    = selector;
      grant_ok_s = fix_ok_s;
    end
    last_grant_d = load_s ? grant_s : last_grant_q;
  end

  // Reset value makes channel 0 the first round-robin winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SEL_W'(NUM_CH - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  logic unused_rr_mode_s;
  assign unused_rr_mode_s = rr_mode;

  always_comb begin
    grant_s    = selector;
    grant_ok_s = fix_ok_s;
  end
`endif

  // A load pops the granted FIFO on the same edge; a stalled output holds everything.
  always_comb begin
    load_s      = (!out_valid_q || out_ready) && grant_ok_s;
    pop_s       = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load_s) begin
      pop_s[grant_s] = 1'b1;
      out_valid_d    = 1'b1;
      out_data_d     = rdata_s[grant_s];
      out_ch_d       = grant_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

endmodule

// File: tb/tb_buffer_arb_mux.sv
// Directed bench for buffer_arb_mux: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_buffer_arb_mux;

  localparam int DW    = 40;
  localparam int NC    = 4;
  localparam int DEPTH = 4;
`ifdef BUFFER_ARB_MUX_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     in_valid, in_ready;
  logic [NC*DW-1:0]  in_data;
  logic [1:0]        selector;
  logic              rr_mode, out_valid, out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_ch;

  logic [2:0]        d3_in_valid, d3_in_ready;
  logic [3*DW-1:0]   d3_in_data;
  logic [1:0]        d3_selector, d3_out_ch;
  logic              d3_out_valid, d3_out_ready;
  logic [DW-1:0]     d3_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq [NC][$];
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_ch;
  int            m_last;
  int            rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  always #5 clk = ~clk;

  buffer_arb_mux u_dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .selector (selector), .rr_mode (rr_mode),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_ch (out_ch)
  );

  buffer_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(3), .FIFO_DEPTH(4)) u_dut3 (
    .clk (clk), .rst_n (rst_n), .in_valid (d3_in_valid), .in_ready (d3_in_ready),
    .in_data (d3_in_data), .selector (d3_selector), .rr_mode (1'b0),
    .out_valid (d3_out_valid), .out_ready (d3_out_ready), .out_data (d3_out_data),
    .out_ch (d3_out_ch)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) mq[c].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_last  = NC - 1;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit ready [NC];
    int g, idx;
    bit gok, load;
    g = 0;
    gok = 1'b0;
    for (int c = 0; c < NC; c++) ready[c] = (mq[c].size() < DEPTH);
    if (RR_EN && rr_mode) begin
      for (int k = 1; k <= NC; k++) begin
        idx = (m_last + k) % NC;
        if (!gok && mq[idx].size() > 0) begin
          g = idx;
          gok = 1'b1;
        end
      end
    end else if (int'(selector) < NC && mq[int'(selector)].size() > 0) begin
      g = int'(selector);
      gok = 1'b1;
    end
    load = (!m_valid || out_ready) && gok;
    if (load) begin
      m_data  = mq[g].pop_front();
      m_valid = 1'b1;
      m_ch    = g;
      m_last  = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    for (int c = 0; c < NC; c++)
      if (in_valid[c] && ready[c]) mq[c].push_back(in_data[c*DW +: DW]);
  endtask

  task automatic compare_model();
    logic [NC-1:0] exp_rdy;
    for (int c = 0; c < NC; c++) exp_rdy[c] = (mq[c].size() < DEPTH);
    check("model_out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("model_out_data", 64'(out_data), 64'(m_data));
      check("model_out_ch", 64'(out_ch), 64'(m_ch));
    end
    check("model_in_ready", 64'(in_ready), 64'(exp_rdy));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    in_valid = '0; in_data = '0; selector = '0; rr_mode = 1'b0; out_ready = 1'b1;
    d3_in_valid = '0; d3_in_data = '0; d3_selector = '0; d3_out_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'hF);
    rst_n = 1'b1;

    // Fixed select, latency
    in_data[0 +: DW] = 40'hABA; in_valid = 4'b0001; selector = 2'd0; out_ready = 1'b1;
    step();
    in_valid = '0;
    check("fix_after_push", 64'(out_valid), 64'd0);
    step();
    check("fix_valid", 64'(out_valid), 64'd1);
    check("fix_data", 64'(out_data), 64'hABA);
    check("fix_ch", 64'(out_ch), 64'd0);
    step();
    check("fix_drained", 64'(out_valid), 64'd0);

    // Backpressure with selector change
    out_ready = 1'b0; in_data[1*DW +: DW] = 40'h2; in_valid = 4'b0010; selector = 2'd1;
    step();
    in_valid = '0;
    step();
    check("bp_load_data", 64'(out_data), 64'h2);
    selector = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", 64'(out_data), 64'h2);
      check("bp_hold_ch", 64'(out_ch), 64'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_release", 64'(out_valid), 64'd0);

    // Full FIFO on ch2
    out_ready = 1'b0; selector = 2'd0; in_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      in_data[2*DW +: DW] = 40'h20 + 40'(i);
      step();
      if (i == 3) check("full_ready_after_4", 64'(in_ready), 64'hB);
    end
    in_valid = '0;
    check("full_ready_after_5", 64'(in_ready), 64'hB);
    selector = 2'd2; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("full_order", 64'(out_data), 64'h20 + 64'(i));
    end
    step();
    check("full_only_4", 64'(out_valid), 64'd0);

    // Reset mid-operation
    out_ready = 1'b0; selector = 2'd0;
    in_data[0 +: DW] = 40'h31; in_data[1*DW +: DW] = 40'h41; in_valid = 4'b0011;
    step();
    in_data[1*DW +: DW] = 40'h42; in_valid = 4'b0010;
    step();
    in_valid = '0;
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    check("mid_pre_data", 64'(out_data), 64'h31);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'hF);
    check("mid_rst_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    in_data[3*DW +: DW] = 40'h55; in_valid = 4'b1000; selector = 2'd3; out_ready = 1'b1;
    step();
    in_valid = '0;
    step();
    check("post_rst_data", 64'(out_data), 64'h55);
    check("post_rst_ch", 64'(out_ch), 64'd3);
    selector = 2'd1;
    step();
    check("post_rst_discard", 64'(out_valid), 64'd0);

    // Round-robin (fixed mode with selector 0 when round-robin is not built)
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rr_mode = 1'b1; out_ready = 1'b1; selector = 2'd0;
    for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = 40'h100 + 40'(c * 16);
    in_valid = 4'hF;
    step();
    for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = 40'h101 + 40'(c * 16);
    for (int i = 0; i < 8; i++) begin
      step();
      in_valid = '0;
`ifdef BUFFER_ARB_MUX_RR_EN
      check("rr_seq", 64'(out_ch), 64'(rr_exp[i]));
`endif
    end
    rr_mode = 1'b0;
    step();

    // Out-of-range selector on a 3-channel instance
    d3_in_data[0 +: DW] = 40'h77; d3_in_valid = 3'b001; d3_selector = 2'd3;
    step();
    d3_in_valid = '0;
    check("inv_ready", 64'(d3_in_ready), 64'h7);
    for (int i = 0; i < 4; i++) begin
      step();
      check("inv_no_load", 64'(d3_out_valid), 64'd0);
    end
    d3_selector = 2'd0;
    step();
    check("inv_recover_valid", 64'(d3_out_valid), 64'd1);
    check("inv_recover_data", 64'(d3_out_data), 64'h77);
    check("inv_recover_ch", 64'(d3_out_ch), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
